// File: rtl/sipo_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_receiver_pkg
// Description : Shared types and helpers for the SIPO serial receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package sipo_receiver_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } t_Sipo_State;

    // Width of the bit counter for a given word width (never below 1 bit).
    function automatic int count_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage : sipo_receiver_pkg
`default_nettype wire

// File: rtl/sipo_output_holding_register.sv
`default_nettype none
// ============================================================================
// Module      : sipo_output_holding_register
// Description : Valid/ready output word register with sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_output_holding_register #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_load_data,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_overrun
);

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_overrun;
    logic                  w_accept;
    logic                  w_free;

    assign w_accept = r_valid & i_ready;
    // The slot can take a new word when empty or being drained this same edge.
    assign w_free   = ~r_valid | i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (i_load && w_free) begin
                r_data  <= i_load_data;
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end

            if (i_clear) begin
                r_overrun <= 1'b0;
            end else if (i_load && !w_free) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule : sipo_output_holding_register
`default_nettype wire

// File: rtl/serial_in_parallel_out_sipo_receiver.sv
`default_nettype none
// ============================================================================
// Module      : serial_in_parallel_out_sipo_receiver
// Description : MSB-first serial-to-parallel receiver with valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_in_parallel_out_sipo_receiver
    import sipo_receiver_pkg::*;
#(
    parameter int DATA_WIDTH  = 4,
    localparam int COUNT_WIDTH = count_width(DATA_WIDTH)
) (
    input  logic                   Clk_In,
    input  logic                   Reset_N_In,
    input  logic                   Enable_In,
    input  logic                   Clear_In,
    input  logic                   Shift_Data_Signal_In,
    input  logic                   Serial_Data_In,
    output logic [DATA_WIDTH-1:0]  Parallel_Data_Out,
    output logic                   Parallel_Valid_Out,
    input  logic                   Parallel_Ready_In,
    output logic [COUNT_WIDTH-1:0] Bit_Count_Out,
    output logic                   Overrun_Error_Out
);

    localparam logic [COUNT_WIDTH-1:0] c_LAST_COUNT = COUNT_WIDTH'(DATA_WIDTH - 1);

    t_Sipo_State            r_state;
    logic [DATA_WIDTH-1:0]  r_shift_register;
    logic [COUNT_WIDTH-1:0] r_bit_count;
    logic                   w_strobe;
    logic                   w_complete;
    logic [DATA_WIDTH-1:0]  w_next_word;

    // Clear outranks the strobe, so a clear cycle never consumes a bit.
    assign w_strobe    = Enable_In & Shift_Data_Signal_In & ~Clear_In;
    assign w_complete  = w_strobe && (r_state == S_SHIFT) && (r_bit_count == c_LAST_COUNT);
    assign w_next_word = {r_shift_register[DATA_WIDTH-2:0], Serial_Data_In};

    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            r_state          <= S_IDLE;
            r_shift_register <= '0;
            r_bit_count      <= '0;
        end else if (Clear_In) begin
            r_state          <= S_IDLE;
            r_shift_register <= '0;
            r_bit_count      <= '0;
        end else if (w_strobe) begin
            r_shift_register <= w_next_word;
            if (w_complete) begin
                r_state     <= S_IDLE;
                r_bit_count <= '0;
            end else begin
                r_state     <= S_SHIFT;
                r_bit_count <= r_bit_count + 1'b1;
            end
        end
    end

    sipo_output_holding_register #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_holding (
        .clk         (Clk_In),
        .rst_n       (Reset_N_In),
        .i_clear     (Clear_In),
        .i_load      (w_complete),
        .i_load_data (w_next_word),
        .i_ready     (Parallel_Ready_In),
        .o_data      (Parallel_Data_Out),
        .o_valid     (Parallel_Valid_Out),
        .o_overrun   (Overrun_Error_Out)
    );

    assign Bit_Count_Out = r_bit_count;

endmodule : serial_in_parallel_out_sipo_receiver
`default_nettype wire

// File: tb/tb_serial_in_parallel_out_sipo_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_in_parallel_out_sipo_receiver
// Description : Directed self-checking bench for the SIPO receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_in_parallel_out_sipo_receiver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       clear;
    logic       strobe;
    logic       serial;
    logic       ready;
    logic [3:0] data;
    logic       valid;
    logic [1:0] count;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    logic [3:0] piso_reg;
    logic [1:0] exp_count [4];

    always #5 clk = ~clk;

    serial_in_parallel_out_sipo_receiver #(.DATA_WIDTH(4)) dut (
        .Clk_In               (clk),
        .Reset_N_In           (rst_n),
        .Enable_In            (enable),
        .Clear_In             (clear),
        .Shift_Data_Signal_In (strobe),
        .Serial_Data_In       (serial),
        .Parallel_Data_Out    (data),
        .Parallel_Valid_Out   (valid),
        .Parallel_Ready_In    (ready),
        .Bit_Count_Out        (count),
        .Overrun_Error_Out    (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        strobe = 1'b1;
        serial = b;
        tick();
        strobe = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        clear  = 1'b0;
        strobe = 1'b1;
        serial = 1'b1;
        ready  = 1'b1;
        repeat (3) tick();
        check("rst_data",    32'(data),    32'h0);
        check("rst_valid",   32'(valid),   32'h0);
        check("rst_count",   32'(count),   32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);

        // First word 1,0,1,1 -> 0xB
        strobe = 1'b0;
        rst_n  = 1'b1;
        tick();
        send_bit(1'b1); check("w1_count1", 32'(count), 32'd1);
        send_bit(1'b0); check("w1_count2", 32'(count), 32'd2);
        send_bit(1'b1); check("w1_count3", 32'(count), 32'd3);
        check("w1_valid_early", 32'(valid), 32'h0);
        send_bit(1'b1);
        check("w1_count0", 32'(count), 32'd0);
        check("w1_data",   32'(data),  32'hB);
        check("w1_valid",  32'(valid), 32'h1);
        tick();
        check("w1_valid_drop", 32'(valid), 32'h0);

        // Bench-side PISO serializer sending 0x6 MSB first
        piso_reg  = 4'h6;
        exp_count = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            send_bit(piso_reg[3]);
            piso_reg = {piso_reg[2:0], 1'b0};
            check("piso_count", 32'(count), 32'(exp_count[i]));
        end
        check("piso_data",  32'(data),  32'h6);
        check("piso_valid", 32'(valid), 32'h1);
        tick();

        // Stall: 0xA then 0x5 with Ready low
        ready = 1'b0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        check("stall_data_a",  32'(data),    32'hA);
        check("stall_valid_a", 32'(valid),   32'h1);
        check("stall_ovr_a",   32'(overrun), 32'h0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check("stall_data_kept", 32'(data),    32'hA);
        check("stall_overrun",   32'(overrun), 32'h1);
        check("stall_count",     32'(count),   32'd0);
        ready = 1'b1;
        tick();
        check("stall_valid_drop", 32'(valid),   32'h0);
        check("stall_ovr_sticky", 32'(overrun), 32'h1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_overrun", 32'(overrun), 32'h0);
        check("clear_data",    32'(data),    32'hA);

        // Accept and completion on the same edge
        ready = 1'b0;
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        check("sim_data_3", 32'(data),  32'h3);
        check("sim_valid3", 32'(valid), 32'h1);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        ready = 1'b1;
        send_bit(1'b0);
        check("sim_data_c",  32'(data),    32'hC);
        check("sim_valid_c", 32'(valid),   32'h1);
        check("sim_overrun", 32'(overrun), 32'h0);
        tick();
        check("sim_valid_drop", 32'(valid), 32'h0);

        // Abort: clear together with a strobe
        send_bit(1'b0); send_bit(1'b1);
        check("abort_count2", 32'(count), 32'd2);
        clear  = 1'b1;
        strobe = 1'b1;
        serial = 1'b1;
        tick();
        clear  = 1'b0;
        strobe = 1'b0;
        check("abort_count0", 32'(count), 32'd0);
        check("abort_valid",  32'(valid), 32'h0);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        check("abort_valid_early", 32'(valid), 32'h0);
        send_bit(1'b0);
        check("abort_data",  32'(data),  32'hC);
        check("abort_valid_word", 32'(valid), 32'h1);
        tick();

        // Enable gating
        send_bit(1'b1);
        check("gate_count1", 32'(count), 32'd1);
        enable = 1'b0;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check("gate_count_hold", 32'(count), 32'd1);
        enable = 1'b1;

        // Reset mid-word
        send_bit(1'b0); send_bit(1'b1);
        check("mid_count3", 32'(count), 32'd3);
        rst_n = 1'b0;
        #2;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_data",  32'(data),  32'h0);
        rst_n = 1'b1;
        tick();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        check("mid_valid_early", 32'(valid), 32'h0);
        send_bit(1'b1);
        check("mid_data",  32'(data),  32'h9);
        check("mid_valid", 32'(valid), 32'h1);
        check("mid_count", 32'(count), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_in_parallel_out_sipo_receiver
`default_nettype wire
